// File: rtl/latch_bank_reader.sv
// Read-side sequencer for gated D-latch storage banks: bursts of settled reads onto a valid/ready stream.
// Optional parity checking is built when LATCH_RD_PARITY_EN is defined.
module latch_bank_reader #(
  parameter int WIDTH  = 8,
  parameter int AW     = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    lat_addr,
  output logic             lat_hold,
  input  logic [WIDTH-1:0] lat_q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
`ifdef LATCH_RD_PARITY_EN
  input  logic             lat_par,
  output logic             out_perr,
`endif
  input  logic             out_ready
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  // The counter walks 0..SETTLE, so capture lands SETTLE+1 edges after the address moved.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);
  localparam logic [AW:0] LEN_ONE    = (AW+1)'(1);

  logic [1:0]  state;
  logic [3:0]  settle_cnt;
  logic [AW:0] remaining;

  logic handshake;
  assign handshake = out_valid & out_ready;

  // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      remaining  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lat_addr   <= '0;
      lat_hold   <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
`ifdef LATCH_RD_PARITY_EN
      out_perr   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              lat_addr   <= base;
              remaining  <= len;
              lat_hold   <= 1'b1;
              busy       <= 1'b1;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            out_data  <= lat_q;
            out_valid <= 1'b1;
`ifdef LATCH_RD_PARITY_EN
            out_perr  <= (^lat_q) ^ lat_par;
`endif
            state     <= ST_PRESENT;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        ST_PRESENT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_ONE) begin
              busy     <= 1'b0;
              lat_hold <= 1'b0;
              done     <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              // Natural AW-bit overflow gives the silent wrap past the top address.
              lat_addr   <= lat_addr + 1'b1;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
